// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants and state encoding for the SPI memory
//                read path (command opcode, address width, byte limit and
//                the read-engine state type).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam int         ADDR_BITS      = 24;
  localparam int         MAX_READ_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bit_timer
//  Description : SPI mode-0 clock generator. Produces sclk with DIV_HALF clk
//                cycles per half-period plus one-cycle strobes marking the
//                clk edge that drives sclk 0->1 (rise) and 1->0 (fall).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk   in   system clock
//    rst_n in   synchronous active-low reset
//    en    in   run the timer; low forces phase 0 and sclk low
//    sclk  out  SPI clock (registered, idle low)
//    rise  out  this clk edge drives sclk 0->1 (miso sample point)
//    fall  out  this clk edge drives sclk 1->0 (mosi shift point)
// ============================================================================
module spi_bit_timer #(
  parameter int DIV_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  // One idle cycle after enable gives cs-to-first-edge setup time before the
  // first sclk low phase begins counting.
  logic             r_started;
  logic             w_tick;

  assign w_tick = en && r_started && (r_cnt == CNT_W'(DIV_HALF - 1));
  assign rise   = w_tick && !r_sclk;
  assign fall   = w_tick &&  r_sclk;
  assign sclk   = r_sclk;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_cnt     <= '0;
      r_sclk    <= 1'b0;
      r_started <= 1'b0;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_mem_read.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mem_read
//  Description : SPI mode-0 read engine. Per request sends the READ opcode and
//                a 24-bit address, clocks in 1-4 bytes and assembles them
//                little-endian into a 32-bit word held with fetch_done until
//                the request is released.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk            in   system clock
//    rst_n          in   synchronous active-low reset
//    start_fetch    in   request level; rising transition starts a read
//    read_bytes     in   byte count (0..15, >4 clamped to 4)
//    target_address in   24-bit byte address
//    target_data    out  assembled read word
//    fetch_done     out  result valid and held
//    miso           in   SPI data from memory
//    sclk           out  SPI clock, idle low
//    mosi           out  SPI data to memory
//    cs             out  SPI chip select, active low
// ============================================================================
module spi_mem_read
  import mem_pkg::*;
#(
  parameter int         DIV_HALF = 1,
  parameter logic [7:0] CMD_READ = SPI_CMD_READ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_fetch,
  input  logic [3:0]  read_bytes,
  input  logic [23:0] target_address,
  output logic [31:0] target_data,
  output logic        fetch_done,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs
);

  spi_state_t  r_state;
  logic        r_start_q;   // registered start_fetch sample
  logic        r_armed;     // start_fetch has been seen low since last start
  logic [2:0]  r_nbytes;
  logic [5:0]  r_bit_cnt;
  logic [30:0] r_tx_sr;     // bits still to send after the one on mosi
  logic [7:0]  r_rx_byte;
  logic [31:0] r_rx_word;

  logic        w_active;
  logic        w_rise;
  logic        w_fall;
  logic [2:0]  w_nbytes;
  logic [5:0]  w_last_data_bit;

  assign w_active = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_nbytes = (read_bytes > 4'(MAX_READ_BYTES)) ? 3'(MAX_READ_BYTES) : read_bytes[2:0];
  assign w_last_data_bit = {r_nbytes, 3'b000} - 6'd1;

  // Dropping start_fetch disables the timer on the same edge the FSM aborts,
  // so sclk returns low together with cs going high.
  spi_bit_timer #(
    .DIV_HALF (DIV_HALF)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_active && start_fetch),
    .sclk  (sclk),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_start_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_nbytes    <= 3'd0;
      r_bit_cnt   <= 6'd0;
      r_tx_sr     <= '0;
      r_rx_byte   <= 8'd0;
      r_rx_word   <= 32'd0;
      target_data <= 32'd0;
      fetch_done  <= 1'b0;
      mosi        <= 1'b0;
      cs          <= 1'b1;
    end else begin
      r_start_q <= start_fetch;
      r_armed   <= r_armed | ~start_fetch;

      case (r_state)
        ST_IDLE: begin
          if (r_start_q && r_armed) begin
            r_armed   <= 1'b0;
            r_nbytes  <= w_nbytes;
            r_bit_cnt <= 6'd0;
            r_rx_word <= 32'd0;
            if (w_nbytes == 3'd0) begin
              r_state     <= ST_DONE;
              fetch_done  <= 1'b1;
              target_data <= 32'd0;
            end else begin
              r_state <= ST_CMD;
              cs      <= 1'b0;
              mosi    <= CMD_READ[7];
              r_tx_sr <= {CMD_READ[6:0], target_address};
            end
          end
        end

        ST_CMD, ST_ADDR, ST_DATA: begin
          if (!start_fetch) begin
            r_state   <= ST_IDLE;
            cs        <= 1'b1;
            mosi      <= 1'b0;
            r_bit_cnt <= 6'd0;
          end else begin
            if (w_rise && (r_state == ST_DATA)) begin
              r_rx_byte <= {r_rx_byte[6:0], miso};
              if (r_bit_cnt[2:0] == 3'd7)
                r_rx_word[{r_bit_cnt[4:3], 3'b000} +: 8] <= {r_rx_byte[6:0], miso};
            end
            if (w_fall) begin
              case (r_state)
                ST_CMD: begin
                  mosi    <= r_tx_sr[30];
                  r_tx_sr <= {r_tx_sr[29:0], 1'b0};
                  if (r_bit_cnt == 6'd7) begin
                    r_state   <= ST_ADDR;
                    r_bit_cnt <= 6'd0;
                  end else begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
                end
                ST_ADDR: begin
                  if (r_bit_cnt == 6'(ADDR_BITS - 1)) begin
                    r_state   <= ST_DATA;
                    r_bit_cnt <= 6'd0;
                    mosi      <= 1'b0;
                  end else begin
                    mosi      <= r_tx_sr[30];
                    r_tx_sr   <= {r_tx_sr[29:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
                end
                default: begin
                  if (r_bit_cnt == w_last_data_bit) begin
                    r_state     <= ST_DONE;
                    cs          <= 1'b1;
                    fetch_done  <= 1'b1;
                    target_data <= r_rx_word;
                  end else begin
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                  end
                end
              endcase
            end
          end
        end

        ST_DONE: begin
          if (!start_fetch) begin
            r_state    <= ST_IDLE;
            fetch_done <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_read.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_mem_read
//  Description : Self-checking bench for spi_mem_read (DIV_HALF=1 and 3)
//                with a behavioural SPI memory per instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_read;

  logic        clk;
  logic        rst_n;
  logic        start1, start3;
  logic [3:0]  rb;
  logic [23:0] ta;
  logic [31:0] td1, td3;
  logic        done1, done3;
  logic        miso1, miso3, sclk1, sclk3, mosi1, mosi3, cs1, cs3;

  int checks = 0;
  int fails  = 0;

  // memory model state
  int          mcnt1 = 0, mcnt3 = 0;
  int          csf1 = 0, csf3 = 0;
  logic [31:0] hdr1 = 0, hdr3 = 0;
  logic [31:0] resp1 = 0, resp3 = 0;

  spi_mem_read #(.DIV_HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_fetch(start1), .read_bytes(rb),
    .target_address(ta), .target_data(td1), .fetch_done(done1),
    .miso(miso1), .sclk(sclk1), .mosi(mosi1), .cs(cs1));

  spi_mem_read #(.DIV_HALF(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_fetch(start3), .read_bytes(rb),
    .target_address(ta), .target_data(td3), .fetch_done(done3),
    .miso(miso3), .sclk(sclk3), .mosi(mosi3), .cs(cs3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte k of resp (bits [8k+7:8k]) is returned MSB first after 32 header bits.
  function automatic logic resp_bit(input logic [31:0] r, input int idx);
    int j;
    if (idx < 32 || idx >= 64) return 1'b0;
    j = idx - 32;
    return r[8 * (j / 8) + 7 - (j % 8)];
  endfunction

  assign miso1 = resp_bit(resp1, mcnt1);
  assign miso3 = resp_bit(resp3, mcnt3);

  always @(negedge cs1) begin mcnt1 = 0; hdr1 = 0; csf1++; end
  always @(negedge cs3) begin mcnt3 = 0; hdr3 = 0; csf3++; end
  always @(posedge sclk1) begin if (mcnt1 < 32) hdr1 = {hdr1[30:0], mosi1}; mcnt1++; end
  always @(posedge sclk3) begin if (mcnt3 < 32) hdr3 = {hdr3[30:0], mosi3}; mcnt3++; end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch1(input logic [3:0] nb, input logic [23:0] a, input logic [31:0] r);
    @(negedge clk);
    rb = nb; ta = a; resp1 = r; mcnt1 = 0;
    start1 = 1'b1;
  endtask

  // Returns the number of clk edges after the edge that first sampled start.
  task automatic wait_done1(output int lat);
    @(posedge clk);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk); lat++; #1;
      if (done1) break;
    end
  endtask

  typedef struct {
    logic [3:0]  nb;
    logic [23:0] addr;
    logic [31:0] resp;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_rises;
    int          exp_csf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, base, bad, prev_s, run, rises;
    logic [31:0] held;

    vecs[0] = '{4'd4, 24'h000104, 32'hDEADBEEF, 32'hDEADBEEF, 130, 64, 1};
    vecs[1] = '{4'd1, 24'h123456, 32'h0000005A, 32'h0000005A,  82, 40, 1};
    vecs[2] = '{4'd0, 24'h00FFFF, 32'hCAFEF00D, 32'h00000000,   1,  0, 0};
    vecs[3] = '{4'd9, 24'h7F0001, 32'h44332211, 32'h44332211, 130, 64, 1};
    vecs[4] = '{4'd2, 24'hABCDEF, 32'h99881234, 32'h00001234,  98, 48, 1};
    vecs[5] = '{4'd3, 24'h800001, 32'hFF030201, 32'h00030201, 114, 56, 1};

    // Reset with the request already high: must not start afterwards.
    rst_n = 1'b0; start1 = 1'b1; start3 = 1'b0; rb = 4'd4; ta = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", cs1, 1); chk("rst_sclk", sclk1, 0); chk("rst_mosi", mosi1, 0);
    chk("rst_done", done1, 0); chk("rst_data", td1, 0);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (6) begin @(posedge clk); #1; if (cs1 !== 1'b1 || done1 !== 1'b0) bad++; end
    chk("held_start_ignored", bad, 0);
    @(negedge clk) start1 = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      base = csf1;
      launch1(vecs[i].nb, vecs[i].addr, vecs[i].resp);
      wait_done1(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_data", i), td1, vecs[i].exp_data);
      chk($sformatf("v%0d_cs_at_done", i), cs1, 1);
      chk($sformatf("v%0d_sclk_at_done", i), sclk1, 0);
      chk($sformatf("v%0d_cs_falls", i), csf1 - base, vecs[i].exp_csf);
      if (vecs[i].exp_rises > 0) begin
        chk($sformatf("v%0d_sclk_rises", i), mcnt1, vecs[i].exp_rises);
        chk($sformatf("v%0d_mosi_hdr", i), hdr1, {8'h03, vecs[i].addr});
      end
      if (i == 0) begin
        bad = 0;
        repeat (10) begin
          @(posedge clk); #1;
          if (done1 !== 1'b1 || td1 !== vecs[0].exp_data) bad++;
        end
        chk("hold_done_stable", bad, 0);
      end
      @(negedge clk) start1 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_clear", i), done1, 0);
      chk($sformatf("v%0d_data_retained", i), td1, vecs[i].exp_data);

      if (i == 0) begin
        // Abort in the middle of the address phase.
        held = td1;
        launch1(4'd4, 24'h555555, 32'h01020304);
        @(posedge clk);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("abort_cs_low_before", cs1, 0);
        start1 = 1'b0;
        @(posedge clk); #1;
        chk("abort_cs", cs1, 1); chk("abort_sclk", sclk1, 0);
        chk("abort_mosi", mosi1, 0); chk("abort_done", done1, 0);
        bad = 0;
        repeat (5) begin @(posedge clk); #1; if (done1 !== 1'b0 || td1 !== held) bad++; end
        chk("abort_quiet", bad, 0);
      end
    end

    // Reset during the data phase.
    launch1(4'd4, 24'h000010, 32'h87654321);
    @(posedge clk);
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("rstdata_cs_low_before", cs1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstdata_cs", cs1, 1); chk("rstdata_sclk", sclk1, 0);
    chk("rstdata_mosi", mosi1, 0); chk("rstdata_done", done1, 0);
    chk("rstdata_data", td1, 0);
    @(negedge clk) begin rst_n = 1'b1; start1 = 1'b0; end
    repeat (2) @(posedge clk);

    // DIV_HALF=3, two bytes: phase lengths and latency.
    @(negedge clk);
    rb = 4'd2; ta = 24'h00FF00; resp3 = 32'h7777A5C3; mcnt3 = 0; base = csf3;
    start3 = 1'b1;
    @(posedge clk);
    lat = 0; bad = 0; prev_s = 0; run = 0; rises = 0;
    while (lat < 800) begin
      @(posedge clk); lat++; #1;
      if (int'(sclk3) != prev_s) begin
        if (prev_s == 1 && run != 3) bad++;
        if (prev_s == 0 && rises > 0 && run != 3) bad++;
        if (sclk3) rises++;
        run = 1;
      end else begin
        run++;
      end
      prev_s = int'(sclk3);
      if (done3) break;
    end
    chk("dh3_latency", lat, 290);
    chk("dh3_data", td3, 32'h0000A5C3);
    chk("dh3_phase_len", bad, 0);
    chk("dh3_rises", rises, 48);
    chk("dh3_model_rises", mcnt3, 48);
    chk("dh3_mosi_hdr", hdr3, {8'h03, 24'h00FF00});
    chk("dh3_cs_falls", csf3 - base, 1);
    @(negedge clk) start3 = 1'b0;
    @(posedge clk); #1;
    chk("dh3_done_clear", done3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
